// File: rtl/aes_cipher_ctrl.sv
// AES-128 encryption round sequencer and state datapath.
// A start in IDLE loads plaintext^key and the cipher key. Each of the 10 rounds
// then takes two cycles: SUB registers the S-box outputs and the next round key,
// and MIX folds shiftrows/mixcolumns/addroundkey back into the state register.
// mixcolumns is skipped in the final round. The ciphertext is latched on the last
// MIX edge and announced by a one-cycle done strobe.
module aes_cipher_ctrl #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] cyphertext
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] MIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  // GF(2^8) multiply by x, using the AES reduction polynomial
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply (shift-and-add)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as x^254 (zero maps to zero), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Round constant for expansion step idx (0..9), which produces round key idx+1
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   fsm_reg;
  logic [3:0]   round_reg;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [127:0] sb_reg;   // registered subbytes output
  logic [127:0] nk_reg;   // registered keyexpansion output (next round key)
  logic [127:0] cyphertext_reg;

  logic [127:0] sb_next;
  logic [127:0] nk_next;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] ark_out;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  ks_temp;
  logic [31:0]  w0_next;
  logic [31:0]  w1_next;
  logic [31:0]  w2_next;
  logic [31:0]  w3_next;
  logic         round_ok;

  // Byte n of a 128-bit block sits at [127-8n -: 8]; column c holds bytes 4c..4c+3.
  genvar gi;

  // subbytes on the current state
  generate
    for (gi = 0; gi < 16; gi++) begin : g_subbytes
      assign sb_next[127-8*gi -: 8] = sbox(state_reg[127-8*gi -: 8]);
    end
  endgenerate

  // keyexpansion: SubWord(RotWord(w3)) ^ Rcon, then the running XOR across words
  assign rot_word = {rk_reg[23:0], rk_reg[31:24]};
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
    end
  endgenerate
  assign ks_temp = sub_word ^ {rcon(round_reg - 4'd1), 24'h000000};
  assign w0_next = rk_reg[127:96] ^ ks_temp;
  assign w1_next = rk_reg[95:64]  ^ w0_next;
  assign w2_next = rk_reg[63:32]  ^ w1_next;
  assign w3_next = rk_reg[31:0]   ^ w2_next;
  assign nk_next = {w0_next, w1_next, w2_next, w3_next};

  // shiftrows: row r of column c takes row r of column (c+r) mod 4
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shiftrows
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
      assign sr_out[127-8*gi -: 8] = sb_reg[127-8*SRC -: 8];
    end
  endgenerate

  // mixcolumns, one column per iteration
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mixcol
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_out[127-32*gi -: 8];
      assign a1 = sr_out[119-32*gi -: 8];
      assign a2 = sr_out[111-32*gi -: 8];
      assign a3 = sr_out[103-32*gi -: 8];
      assign mc_out[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc_out[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc_out[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc_out[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  // addroundkey; the final round bypasses mixcolumns
  assign ark_out = ((round_reg == LAST_ROUND) ? sr_out : mc_out) ^ nk_reg;

  assign round_ok = (round_reg >= 4'd1) && (round_reg <= LAST_ROUND);

  // Round sequencer and state/key/ciphertext registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg        <= IDLE;
      round_reg      <= 4'd0;
      state_reg      <= '0;
      rk_reg         <= '0;
      sb_reg         <= '0;
      nk_reg         <= '0;
      cyphertext_reg <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (start) begin
            state_reg <= plaintext ^ key;
            rk_reg    <= key;
            round_reg <= 4'd1;
            fsm_reg   <= SUB;
          end
        end
        SUB: begin
          if (!round_ok) begin
            fsm_reg <= IDLE;
          end else begin
            sb_reg  <= sb_next;
            nk_reg  <= nk_next;
            fsm_reg <= MIX;
          end
        end
        MIX: begin
          if (!round_ok) begin
            fsm_reg <= IDLE;
          end else begin
            state_reg <= ark_out;
            rk_reg    <= nk_reg;
            if (round_reg == LAST_ROUND) begin
              cyphertext_reg <= ark_out;
              fsm_reg        <= DONE;
            end else begin
              round_reg <= round_reg + 4'd1;
              fsm_reg   <= SUB;
            end
          end
        end
        default: fsm_reg <= IDLE;   // DONE: single strobe cycle, start ignored
      endcase
    end
  end

  assign busy       = (fsm_reg == SUB) || (fsm_reg == MIX);
  assign done       = (fsm_reg == DONE);
  assign cyphertext = cyphertext_reg;

endmodule
